reset_sequencer: RTL
====================

# reset_sequencer

Parametrised reset controller for the mil1553-spi design. It merges several asynchronous active-low reset requests, such as an SPI command, a bus command or a watchdog, into one stretched reset. It then releases several downstream reset domains in a fixed staggered order, and it records which source caused the last reset. It sits between the board reset input and every internal block that consumes a reset.

## Interface
Parameters:
- REQ_CNT, 2: number of reset request inputs, ≥1.
- SYNC_DEPTH, 3: synchroniser/debounce depth per request, ≥2.
- PULSE_LEN, 16: cycles of full reset after the last request is released, ≥1.
- OUT_CNT, 2: number of reset output domains, ≥1.
- STAGGER, 4: cycles between consecutive domain releases, ≥1.

Ports:
- clk  in  1  system clock.
- nRst  in  1  synchronous active-low reset.
- nResetRequest  in  REQ_CNT  asynchronous active-low requests; bit i is channel i.
- causeClear  in  1  one-cycle pulse that clears resetCause.
- nResetOut  out  OUT_CNT  active-low domain resets; bit 0 is released first.
- resetCause  out  REQ_CNT+1  sticky cause flags; bit i is channel i, bit REQ_CNT is power-on (nRst).
- busy  out  1  high while the state is not IDLE.

## Operation
- Per channel:
  - A SYNC_DEPTH shift register samples nResetRequest[i] on every clk edge; reset value is all ones.
  - The channel is asserted when all samples are 0 and deasserted when any sample is 1. This gives SYNC_DEPTH-cycle debounce on assertion and 1-cycle release.
  - reqAny = OR of all asserted channels.
- State machine, states IDLE, HOLD, PULSE, RELEASE, with one counter cnt:
  - IDLE: all outputs high. reqAny → HOLD.
  - HOLD: all outputs low, cnt=0. Stays while reqAny. !reqAny → PULSE, cnt=0.
  - PULSE: all outputs low, cnt increments. reqAny → HOLD. cnt==PULSE_LEN-1 → RELEASE, cnt=0, nResetOut[0]=1. If OUT_CNT==1, go → IDLE instead.
  - RELEASE: cnt increments. nResetOut[k] goes high on the edge where cnt becomes k·STAGGER. The edge releasing bit OUT_CNT-1 also moves the state to IDLE. reqAny → HOLD, with all outputs low on that same edge.
- nRst low:
  - Shift registers go to all ones and the state goes to PULSE with cnt=0.
  - nResetOut goes to 0 combinationally (gated with nRst) and stays registered at 0.
  - resetCause goes to only bit REQ_CNT set.
  - busy goes to 1.
  - Power-on therefore gets the full PULSE_LEN stretch and the staggered release.
- resetCause:
  - On every edge where the state is HOLD, the bit of each asserted channel is ORed in.
  - causeClear clears all bits, including the POR bit.
  - If a clear and a set happen on the same edge, the set wins for the bits being set.
  - Cause bits are not cleared by request-driven resets.
- Arithmetic:
  - cnt width is $clog2(max(PULSE_LEN, (OUT_CNT-1)·STAGGER+1)+1).
  - cnt never wraps; it is reset on every state entry.

## Timing
- All outputs are registered, except that nRst forces nResetOut low combinationally.
- Assert latency: a request going low before edge 1 makes the channel asserted after edge SYNC_DEPTH. Outputs go low and the state enters HOLD at edge SYNC_DEPTH+1.
- Release latency:
  - The request goes high before edge 1; the channel deasserts after edge 1; the state enters PULSE at edge 2.
  - nResetOut[0] rises at edge 2+PULSE_LEN.
  - nResetOut[k] rises k·STAGGER edges after nResetOut[0].
- A request shorter than SYNC_DEPTH cycles is ignored.
- A retrigger during PULSE or RELEASE restarts the whole sequence; partial releases are never kept.
- busy rises on the same edge as the HOLD entry and falls on the edge where the last output is released.

## Structure
- rstctl_pkg holds the state enum (IDLE, HOLD, PULSE, RELEASE) and the cnt-width helper function.
- Sub-module reset_req_sync: one channel's shift register plus its assert detector, instantiated REQ_CNT times in a generate loop.
- The top level holds the FSM, the counter, the output registers and the cause register.

## Test plan
All scenarios use default parameters.
- Power-on: hold nRst low for 5 cycles, then release → nResetOut=00 for 16 edges, bit0 rises at edge 16, bit1 at edge 20, busy falls at edge 20, resetCause=100.
- Channel 0 held low for 10 cycles → outputs low 4 edges after the fall. Bit0 rises 18 edges after the request rises, bit1 4 edges later. resetCause=101, or 001 after a prior causeClear.
- Glitch on channel 1 low for 2 cycles → no output change, busy stays 0, resetCause unchanged.
- Channel 1 re-asserts 2 cycles after bit0 is released in RELEASE → both outputs low again on the HOLD-entry edge. A full 16+4 cycle sequence follows the release, and resetCause bit1 is set.
- Both channels fall on the same cycle → resetCause gains 011. causeClear on the same edge as the HOLD entry still leaves 011.
- nRst pulsed low mid-PULSE → outputs go low immediately, the sequence restarts from PULSE with cnt=0, and resetCause=100.

Source files
------------

// File: rtl/rstctl_pkg.sv
// Shared state encoding and counter sizing for the reset sequencer.
package rstctl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_PULSE   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Counter must hold both the stretch length and the last stagger offset.
    function automatic int cnt_width(input int pulse_len, input int out_cnt, input int stagger);
        int span;
        span = (out_cnt - 1) * stagger + 1;
        if (pulse_len > span) span = pulse_len;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/reset_req_sync.sv
// One reset request channel: sampling shift register plus all-low assert detector.
// Asserts after SYNC_DEPTH consecutive low samples, releases one cycle after any high sample.
module reset_req_sync
    import rstctl_pkg::*;
#(
    parameter int SYNC_DEPTH = 3
) (
    input  logic clk,
    input  logic nRst,
    input  logic request,
    output logic asserted
);

    logic [SYNC_DEPTH-1:0] samples;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            samples <= '1;
        end else begin
            samples <= {samples[SYNC_DEPTH-2:0], request};
        end
    end

    assign asserted = (samples == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Merges debounced reset requests into one stretched reset, releases domains in staggered order.
// Outputs registered; nRst also gates nResetOut low combinationally.
module reset_sequencer
    import rstctl_pkg::*;
#(
    parameter int REQ_CNT    = 2,
    parameter int SYNC_DEPTH = 3,
    parameter int PULSE_LEN  = 16,
    parameter int OUT_CNT    = 2,
    parameter int STAGGER    = 4
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [REQ_CNT-1:0] nResetRequest,
    input  logic               causeClear,
    output logic [OUT_CNT-1:0] nResetOut,
    output logic [REQ_CNT:0]   resetCause,
    output logic               busy
);

    localparam int CW = cnt_width(PULSE_LEN, OUT_CNT, STAGGER);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] LAST_REL   = CW'((OUT_CNT - 1) * STAGGER);

    logic [REQ_CNT-1:0] asserted;
    logic               req_any;
    logic [1:0]         state, state_next;
    logic [CW-1:0]      cnt, cnt_next, cnt_inc;
    logic [OUT_CNT-1:0] out_q, out_next;
    logic [REQ_CNT:0]   cause, cause_next;

    for (genvar i = 0; i < REQ_CNT; i++) begin : g_req
        reset_req_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
            .clk      (clk),
            .nRst     (nRst),
            .request  (nResetRequest[i]),
            .asserted (asserted[i])
        );
    end

    assign req_any = |asserted;
    assign cnt_inc = cnt + CW'(1);

    // Any request during PULSE or RELEASE drops every domain and restarts from HOLD.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out_q;
        case (state)
            ST_IDLE: begin
                out_next = '1;
                if (req_any) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    out_next   = '0;
                end
            end
            ST_HOLD: begin
                out_next = '0;
                cnt_next = '0;
                if (!req_any) state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (req_any) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    out_next   = '0;
                end else if (cnt == PULSE_LAST) begin
                    cnt_next = '0;
                    if (OUT_CNT == 1) begin
                        state_next = ST_IDLE;
                        out_next   = '1;
                    end else begin
                        state_next  = ST_RELEASE;
                        out_next[0] = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (req_any) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    out_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                    for (int k = 1; k < OUT_CNT; k++) begin
                        if (cnt_inc == CW'(k * STAGGER)) out_next[k] = 1'b1;
                    end
                    if (cnt_inc == LAST_REL) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                out_next   = '1;
            end
        endcase
    end

    // A set on the same edge as a clear survives for the bits being set.
    always_comb begin
        cause_next = causeClear ? '0 : cause;
        if (state == ST_HOLD) cause_next = cause_next | {1'b0, asserted};
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state <= ST_PULSE;
            cnt   <= '0;
            out_q <= '0;
            cause <= {1'b1, {REQ_CNT{1'b0}}};
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out_q <= out_next;
            cause <= cause_next;
        end
    end

    assign nResetOut  = out_q & {OUT_CNT{nRst}};
    assign resetCause = cause;
    assign busy       = (state != ST_IDLE);

endmodule
